systolic_output_drain: RTL
==========================

// Module: systolic_output_drain
// PURPOSE
//  Downstream stage of the systolic array: captures completed output-matrix rows
//  (N lanes x WIDTH) from the array's row-out port and buffers them in a small FIFO.
//  Writes each row to memory through a valid/ready write port at base + row*ROW_STRIDE.
//  Signals done once all N rows of one result matrix are committed.
// PARAMETERS
//  N          4   array dimension; rows per matrix and lanes per row
//  WIDTH      16  lane width (fp16)
//  DEPTH      4   row FIFO depth; power of 2, >=2
//  ADDR_W     32  memory address width
//  ROW_STRIDE 8   address increment per row (bytes)
// PORTS
//  clk        in   1          clock
//  nRST       in   1          async reset, active-low
//  start      in   1          begin draining one matrix; sampled only in IDLE
//  base_addr  in   ADDR_W     matrix base address, latched on accepted start
//  row_valid  in   1          array presents a completed row
//  row_idx    in   $clog2(N)  index of presented row
//  row_data   in   WIDTH*N    row payload; lane k = [k*WIDTH +: WIDTH]
//  row_ready  out  1          row accepted when row_valid && row_ready
//  wr_valid   out  1          memory write request
//  wr_addr    out  ADDR_W     write address
//  wr_data    out  WIDTH*N    write payload
//  wr_ready   in   1          memory accepts when wr_valid && wr_ready
//  busy       out  1          high in DRAIN
//  done       out  1          one-cycle pulse after row N-1 is written
//  seq_err    out  1          sticky: row arrived out of order
// BEHAVIOUR
//  Reset: state=IDLE; FIFO empty; row/write counters=0; all outputs 0.
//  Reset mid-operation discards FIFO contents and pending writes; no done pulse.
//  FSM IDLE -> DRAIN on start (latch base_addr, clear counters and seq_err).
//    DRAIN -> DONE on the wr handshake of the N-th row. DONE -> IDLE after 1 cycle.
//    done=1 only in DONE. start outside IDLE is ignored.
//  row_ready = (state==DRAIN) && !fifo_full && (rows_in < N). Rows beyond N are not accepted.
//  Expected order 0..N-1. If row_idx != rows_in at acceptance, seq_err is set.
//    The row is still stored, tagged with its row_idx.
//  FIFO entry = {row_idx, row_data}; write is registered.
//    Accepted at edge t -> wr_valid high from cycle t+1 (1-cycle latency).
//  wr_valid = !fifo_empty. wr_data and wr_addr come from the FIFO head combinationally.
//  wr_addr = base_q + row_idx*ROW_STRIDE, computed modulo 2^ADDR_W.
//  While wr_valid && !wr_ready, wr_valid/wr_addr/wr_data hold stable.
//  Simultaneous push and pop: allowed whenever !full; occupancy unchanged.
//    Full with a pop pending: row_ready stays 0 that cycle (no bypass).
//  Pointers wrap modulo DEPTH; occupancy counter is $clog2(DEPTH)+1 bits.
// CONFIGURATION
//  OUTPUT_RELU_EN defined: lanes with sign bit [WIDTH-1]=1 are forced to 0 at FIFO write.
//    Applies to -0 and negative NaN as well.
//  OUTPUT_RELU_EN undefined: row_data is stored and written unmodified.
//  Both variants keep identical latency and ports.
// STRUCTURE
//  systolic_array_pkg: drain_state_t enum {IDLE, DRAIN, DONE}; FP16_SIGN_BIT constant;
//    sa_row_t typedef (logic [WIDTH*N-1:0]).
//  Sub-module sa_row_fifo (params DATA_W, DEPTH): push/pop, full/empty, registered storage.
//  Top holds FSM, counters, address generation, ReLU mask, seq_err.
// TESTING
//  1 start base=0x1000; rows 0..3 back-to-back, wr_ready=1
//    -> writes at 0x1000/08/10/18, each 1 cycle after accept; done pulses once; busy falls.
//  2 wr_ready=0 for 10 cycles while rows stream
//    -> row_ready drops after DEPTH rows; wr_* held stable; no row lost or duplicated.
//  3 row_idx sequence 0,2,1,3 -> seq_err=1 at 2nd accept; addresses 0x1000,0x1010,0x1008,0x1018.
//  4 nRST asserted with 2 rows buffered
//    -> all outputs 0 immediately; no done; next start drains a fresh matrix cleanly.
//  5 OUTPUT_RELU_EN: lane 0xC000 (-2.0) -> 0x0000; lane 0x4000 (+2.0) unchanged.
//    Without the macro: both unchanged.
//  6 start pulsed during DRAIN, and a 5th row offered
//    -> start ignored, base unchanged; 5th row not accepted (row_ready=0).

Source files
------------

// File: rtl/systolic_array_pkg.sv
`default_nettype none
// ============================================================================
// Module  : systolic_array_pkg
// Purpose : Shared types and constants for the systolic array output path.
// Rev     : 1.0  initial release
// ============================================================================
package systolic_array_pkg;

    localparam int SA_N          = 4;
    localparam int SA_WIDTH      = 16;
    localparam int FP16_SIGN_BIT = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } drain_state_t;

    typedef logic [SA_WIDTH*SA_N-1:0] sa_row_t;

endpackage
`default_nettype wire

// File: rtl/sa_row_fifo.sv
`default_nettype none
// ============================================================================
// Module  : sa_row_fifo
// Purpose : Small synchronous FIFO holding completed rows awaiting write-out.
//           DEPTH must be a power of two so the pointers wrap naturally.
// Rev     : 1.0  initial release
// ============================================================================
module sa_row_fifo #(
    parameter int DATA_W = 66,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              push_ok;
    logic              pop_ok;

    // Push is refused when full even if a pop is pending (no bypass).
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rd_ptr_q];

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/systolic_output_drain.sv
`default_nettype none
// ============================================================================
// Module  : systolic_output_drain
// Purpose : Captures completed output rows from the systolic array, buffers
//           them, and writes each to memory at base + row_idx*ROW_STRIDE.
//           Pulses done after all N rows of a matrix have been written.
//           Optional macro OUTPUT_RELU_EN clamps negative lanes to zero.
// Rev     : 1.0  initial release
// ============================================================================
module systolic_output_drain
    import systolic_array_pkg::*;
#(
    parameter int N          = 4,
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 4,
    parameter int ADDR_W     = 32,
    parameter int ROW_STRIDE = 8
) (
    input  logic                 clk,
    input  logic                 nRST,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic                 row_valid,
    input  logic [$clog2(N)-1:0] row_idx,
    input  logic [WIDTH*N-1:0]   row_data,
    output logic                 row_ready,
    output logic                 wr_valid,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [WIDTH*N-1:0]   wr_data,
    input  logic                 wr_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 seq_err
);

    localparam int IDX_W   = $clog2(N);
    localparam int CNT_W   = $clog2(N) + 1;
    localparam int ROW_W   = WIDTH * N;
    localparam int ENTRY_W = IDX_W + ROW_W;
    localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(ROW_STRIDE);

    drain_state_t      state_q;
    drain_state_t      state_d;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  rows_in_q;
    logic [CNT_W-1:0]  wr_cnt_q;
    logic              seq_err_q;

    logic              start_acc;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [ROW_W-1:0]  push_data;
    logic [ENTRY_W-1:0] head;
    logic [IDX_W-1:0]  head_idx;
    logic [ROW_W-1:0]  head_data;

    assign start_acc = (state_q == IDLE) && start;
    assign row_ready = (state_q == DRAIN) && !fifo_full && (rows_in_q < CNT_W'(N));
    assign push      = row_valid && row_ready;
    assign pop       = wr_valid && wr_ready;

`ifdef OUTPUT_RELU_EN
    localparam int SIGN_BIT = (WIDTH == 16) ? FP16_SIGN_BIT : WIDTH - 1;
    // Clamp any lane with its sign bit set (including -0 and negative NaN).
    for (genvar k = 0; k < N; k++) begin : g_relu
        assign push_data[k*WIDTH +: WIDTH] =
            row_data[k*WIDTH + SIGN_BIT] ? '0 : row_data[k*WIDTH +: WIDTH];
    end
`else
    assign push_data = row_data;
`endif

    sa_row_fifo #(
        .DATA_W (ENTRY_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .nRST    (nRST),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  ({row_idx, push_data}),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Write port is driven straight from the FIFO head; it holds while stalled
    // because the head only moves on a handshake. Zeroed when nothing pending.
    assign head_idx  = head[ENTRY_W-1 -: IDX_W];
    assign head_data = head[ROW_W-1:0];
    assign wr_valid  = !fifo_empty;
    assign wr_data   = fifo_empty ? '0 : head_data;
    assign wr_addr   = fifo_empty ? '0 : (base_q + ADDR_W'(head_idx) * STRIDE_A);
    assign seq_err   = seq_err_q;

    // State register.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: finish on the handshake of the N-th write.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = DRAIN;
            DRAIN:   if (pop && (wr_cnt_q == CNT_W'(N - 1))) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            DRAIN:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Base latch, row/write counters and sticky ordering error.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            base_q    <= '0;
            rows_in_q <= '0;
            wr_cnt_q  <= '0;
            seq_err_q <= 1'b0;
        end else if (start_acc) begin
            base_q    <= base_addr;
            rows_in_q <= '0;
            wr_cnt_q  <= '0;
            seq_err_q <= 1'b0;
        end else begin
            if (push) begin
                rows_in_q <= rows_in_q + CNT_W'(1);
                if (CNT_W'(row_idx) != rows_in_q) begin
                    seq_err_q <= 1'b1;
                end
            end
            if (pop) begin
                wr_cnt_q <= wr_cnt_q + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire
